// File: rtl/aer_spike_encoder.sv
// AER transmit encoder: timestamps spikes from 16 channels, arbitrates them
// round-robin and streams {channel_id, timestamp} words through a FWFT FIFO.
module aer_spike_encoder #(
  parameter int unsigned NUM_CH     = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TS_DIV     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] spike_in,
  output logic [23:0]       aer_out,
  output logic              aer_valid,
  input  logic              aer_ready,
  output logic              fifo_full,
  output logic [7:0]        drop_count,
  output logic [19:0]       ts_now
);
  localparam int unsigned CH_W   = 4;
  localparam int unsigned TS_W   = 20;
  localparam int unsigned WORD_W = CH_W + TS_W;
  localparam int unsigned DROP_W = 8;
  localparam int unsigned SUM_W  = DROP_W + 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned DIV_W  = (TS_DIV > 1) ? $clog2(TS_DIV) : 1;
  localparam int unsigned POP_W  = $clog2(NUM_CH + 1);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic [TS_W-1:0] ts;
  } aer_word_t;

  logic [DIV_W-1:0]  div_cnt;
  logic              ts_tick_c;
  logic [NUM_CH-1:0] pending;
  logic [TS_W-1:0]   ts_reg [NUM_CH];
  logic [CH_W-1:0]   last_grant;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_n_c;
  logic [CNT_W-1:0]  count, cnt_after_pop_c, count_n_c;

  logic              gnt_found_c, grant_c, pop_c;
  logic [CH_W-1:0]   gnt_idx_c, cand_c;
  aer_word_t         push_word_c;
  logic [WORD_W-1:0] head_n_c;
  logic [NUM_CH-1:0] gnt_vec_c, held_c, drop_vec_c, load_vec_c, pending_n_c;
  logic [POP_W-1:0]  drop_pop_c;
  logic [SUM_W-1:0]  drop_sum_c;
  logic [DROP_W-1:0] drop_n_c;

  // Timestamp prescaler and free-running wrap-around counter
  assign ts_tick_c = (div_cnt == DIV_W'(TS_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      ts_now  <= '0;
    end else if (ts_tick_c) begin
      div_cnt <= '0;
      ts_now  <= ts_now + TS_W'(1);
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Round-robin search starting one past the last granted channel
  always_comb begin
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    cand_c      = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand_c = last_grant + CH_W'(k);
      if (!gnt_found_c && pending[cand_c]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = cand_c;
      end
    end
  end

  // FIFO control; the registered head is the word visible after this edge
  always_comb begin
    pop_c           = aer_valid && aer_ready;
    grant_c         = gnt_found_c && (!fifo_full || pop_c);
    push_word_c.ch  = gnt_idx_c;
    push_word_c.ts  = ts_reg[gnt_idx_c];
    cnt_after_pop_c = count - CNT_W'(pop_c);
    count_n_c       = cnt_after_pop_c + CNT_W'(grant_c);
    rd_ptr_n_c      = rd_ptr + PTR_W'(pop_c);
    head_n_c        = '0;
    if (cnt_after_pop_c != '0) begin
      head_n_c = mem[rd_ptr_n_c];
    end else if (grant_c) begin
      head_n_c = push_word_c;
    end
  end

  // Capture and drop detection; a channel granted this edge may re-arm
  always_comb begin
    gnt_vec_c = '0;
    if (grant_c) begin
      gnt_vec_c[gnt_idx_c] = 1'b1;
    end
    held_c      = pending & ~gnt_vec_c;
    drop_vec_c  = spike_in & held_c;
    load_vec_c  = spike_in & ~held_c;
    pending_n_c = held_c | spike_in;
    drop_pop_c  = POP_W'($countones(drop_vec_c));
    drop_sum_c  = {1'b0, drop_count} + SUM_W'(drop_pop_c);
    drop_n_c    = (drop_sum_c > SUM_W'(DROP_MAX)) ? DROP_MAX : drop_sum_c[DROP_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (grant_c) begin
      mem[wr_ptr] <= push_word_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      last_grant <= '1;
      drop_count <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      aer_out    <= '0;
      aer_valid  <= 1'b0;
      fifo_full  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        ts_reg[i] <= '0;
      end
    end else begin
      pending    <= pending_n_c;
      drop_count <= drop_n_c;
      for (int i = 0; i < NUM_CH; i++) begin
        if (load_vec_c[i]) begin
          ts_reg[i] <= ts_now;
        end
      end
      if (grant_c) begin
        last_grant <= gnt_idx_c;
        wr_ptr     <= wr_ptr + PTR_W'(1);
      end
      rd_ptr    <= rd_ptr_n_c;
      count     <= count_n_c;
      aer_out   <= head_n_c;
      aer_valid <= (count_n_c != '0);
      fifo_full <= (count_n_c == CNT_W'(FIFO_DEPTH));
    end
  end

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Self-checking bench for aer_spike_encoder: directed scenarios plus random
// traffic compared against a queue-based behavioural model.
module tb_aer_spike_encoder;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] spike_in = '0;
  logic        aer_ready = 1'b0;
  logic [23:0] aer_out;
  logic        aer_valid;
  logic        fifo_full;
  logic [7:0]  drop_count;
  logic [19:0] ts_now;

  int checks = 0;
  int failures = 0;

  aer_spike_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spike_in   (spike_in),
    .aer_out    (aer_out),
    .aer_valid  (aer_valid),
    .aer_ready  (aer_ready),
    .fifo_full  (fifo_full),
    .drop_count (drop_count),
    .ts_now     (ts_now)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int          m_ts;
  bit          m_pend [16];
  logic [19:0] m_tsr [16];
  int          m_last;
  logic [23:0] m_q [$];
  int          m_drops;

  task automatic model_reset();
    m_ts = 0;
    m_last = 15;
    m_drops = 0;
    m_q.delete();
    for (int i = 0; i < 16; i++) begin
      m_pend[i] = 1'b0;
      m_tsr[i] = '0;
    end
  endtask

  task automatic model_edge(input logic [15:0] spk, input logic rdy);
    bit pop;
    bit found;
    int c;
    pop = (m_q.size() != 0) && rdy;
    found = 1'b0;
    c = 0;
    for (int k = 1; k <= 16; k++) begin
      if (!found && m_pend[(m_last + k) % 16]) begin
        found = 1'b1;
        c = (m_last + k) % 16;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (found && m_q.size() < DEPTH) begin
      m_q.push_back({4'(c), m_tsr[c]});
      m_pend[c] = 1'b0;
      m_last = c;
    end
    for (int i = 0; i < 16; i++) begin
      if (spk[i]) begin
        if (m_pend[i]) begin
          if (m_drops < 255) m_drops++;
        end else begin
          m_pend[i] = 1'b1;
          m_tsr[i] = 20'(m_ts);
        end
      end
    end
    m_ts = (m_ts + 1) & 32'hFFFFF;
  endtask

  task automatic step(input logic [15:0] spk, input logic rdy);
    spike_in = spk;
    aer_ready = rdy;
    @(posedge clk);
    model_edge(spk, rdy);
    #1;
    spike_in = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    spike_in = '0;
    aer_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (aer_out !== 24'h0) begin failures++; $display("FAIL rst_aer_out got=%h exp=000000", aer_out); end
    checks++; if (aer_valid !== 1'b0) begin failures++; $display("FAIL rst_aer_valid got=%b exp=0", aer_valid); end
    checks++; if (fifo_full !== 1'b0) begin failures++; $display("FAIL rst_fifo_full got=%b exp=0", fifo_full); end
    checks++; if (drop_count !== 8'h0) begin failures++; $display("FAIL rst_drop_count got=%0d exp=0", drop_count); end
    checks++; if (ts_now !== 20'h0) begin failures++; $display("FAIL rst_ts_now got=%h exp=00000", ts_now); end
    do_reset();
    checks++; if (ts_now !== 20'h0 || aer_valid !== 1'b0) begin failures++; $display("FAIL rst_release got ts=%h valid=%b exp ts=00000 valid=0", ts_now, aer_valid); end
  endtask

  task automatic test_single();
    do_reset();
    repeat (5) step(16'h0, 1'b1);
    checks++; if (ts_now !== 20'd5) begin failures++; $display("FAIL single_ts got=%h exp=00005", ts_now); end
    step(16'h0001, 1'b1);
    checks++; if (aer_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", aer_valid); end
    step(16'h0, 1'b1);
    checks++; if (aer_valid !== 1'b1 || aer_out !== 24'h000005) begin failures++; $display("FAIL single_word got valid=%b out=%h exp valid=1 out=000005", aer_valid, aer_out); end
    step(16'h0, 1'b1);
    checks++; if (aer_valid !== 1'b0 || aer_out !== 24'h0) begin failures++; $display("FAIL single_drain got valid=%b out=%h exp valid=0 out=000000", aer_valid, aer_out); end
  endtask

  task automatic test_simultaneous();
    logic [23:0] exp_w [3];
    exp_w[0] = 24'h00000A;
    exp_w[1] = 24'h10000A;
    exp_w[2] = 24'hF0000A;
    do_reset();
    repeat (10) step(16'h0, 1'b1);
    step(16'h8003, 1'b1);
    for (int j = 0; j < 3; j++) begin
      step(16'h0, 1'b1);
      checks++; if (aer_valid !== 1'b1 || aer_out !== exp_w[j]) begin failures++; $display("FAIL simul_word%0d got valid=%b out=%h exp valid=1 out=%h", j, aer_valid, aer_out, exp_w[j]); end
    end
    step(16'h0, 1'b1);
    checks++; if (aer_valid !== 1'b0) begin failures++; $display("FAIL simul_end_valid got=%b exp=0", aer_valid); end
  endtask

  task automatic test_back_pressure();
    logic [23:0] got [16];
    int n;
    do_reset();
    repeat (2) step(16'h0, 1'b0);
    step(16'h03FF, 1'b0);
    repeat (8) step(16'h0, 1'b0);
    checks++; if (fifo_full !== 1'b1 || aer_out !== 24'h000002) begin failures++; $display("FAIL bp_full got full=%b out=%h exp full=1 out=000002", fifo_full, aer_out); end
    for (int j = 0; j < 3; j++) begin
      step(16'h0, 1'b0);
      checks++; if (fifo_full !== 1'b1 || aer_valid !== 1'b1 || aer_out !== 24'h000002) begin failures++; $display("FAIL bp_hold%0d got full=%b valid=%b out=%h exp full=1 valid=1 out=000002", j, fifo_full, aer_valid, aer_out); end
    end
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 10; cyc++) begin
      if (aer_valid) begin
        got[n] = aer_out;
        n++;
      end
      step(16'h0, 1'b1);
    end
    checks++; if (n != 10) begin failures++; $display("FAIL bp_count got=%0d exp=10", n); end
    for (int j = 0; j < n; j++) begin
      checks++; if (got[j] !== {4'(j), 20'h00002}) begin failures++; $display("FAIL bp_word%0d got=%h exp=%h", j, got[j], {4'(j), 20'h00002}); end
    end
    checks++; if (drop_count !== 8'd0 || aer_valid !== 1'b0) begin failures++; $display("FAIL bp_end got drops=%0d valid=%b exp drops=0 valid=0", drop_count, aer_valid); end
  endtask

  task automatic test_drop();
    logic [23:0] got [16];
    int n;
    do_reset();
    step(16'h00FF, 1'b0);
    repeat (8) step(16'h0, 1'b0);
    checks++; if (fifo_full !== 1'b1) begin failures++; $display("FAIL drop_full got=%b exp=1", fifo_full); end
    step(16'h0008, 1'b0);
    step(16'h0008, 1'b0);
    checks++; if (drop_count !== 8'd1) begin failures++; $display("FAIL drop_count got=%0d exp=1", drop_count); end
    n = 0;
    for (int cyc = 0; cyc < 40 && n < 9; cyc++) begin
      if (aer_valid) begin
        got[n] = aer_out;
        n++;
      end
      step(16'h0, 1'b1);
    end
    checks++; if (n != 9) begin failures++; $display("FAIL drop_words got=%0d exp=9", n); end
    checks++; if (n == 9 && got[8] !== 24'h300009) begin failures++; $display("FAIL drop_ch3_ts got=%h exp=300009", got[8]); end
    checks++; if (drop_count !== 8'd1) begin failures++; $display("FAIL drop_count_end got=%0d exp=1", drop_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    step(16'h0, 1'b1);
    force dut.ts_now = 20'hFFFFD;
    #1 release dut.ts_now;
    m_ts = 32'hFFFFD;
    step(16'h0, 1'b1);
    step(16'h0, 1'b1);
    checks++; if (ts_now !== 20'hFFFFF) begin failures++; $display("FAIL wrap_pre got=%h exp=FFFFF", ts_now); end
    step(16'h0004, 1'b1);
    checks++; if (ts_now !== 20'h00000) begin failures++; $display("FAIL wrap_roll got=%h exp=00000", ts_now); end
    step(16'h0, 1'b1);
    checks++; if (aer_valid !== 1'b1 || aer_out !== 24'h2FFFFF) begin failures++; $display("FAIL wrap_word0 got valid=%b out=%h exp valid=1 out=2FFFFF", aer_valid, aer_out); end
    step(16'h0004, 1'b1);
    step(16'h0, 1'b1);
    checks++; if (aer_valid !== 1'b1 || aer_out !== 24'h200001) begin failures++; $display("FAIL wrap_word1 got valid=%b out=%h exp valid=1 out=200001", aer_valid, aer_out); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(16'h000F, 1'b0);
    step(16'h0002, 1'b0);
    repeat (3) step(16'h0, 1'b0);
    checks++; if (aer_valid !== 1'b1 || drop_count !== 8'd1) begin failures++; $display("FAIL arst_pre got valid=%b drops=%0d exp valid=1 drops=1", aer_valid, drop_count); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (aer_valid !== 1'b0 || aer_out !== 24'h0 || fifo_full !== 1'b0) begin failures++; $display("FAIL arst_out got valid=%b out=%h full=%b exp 0/000000/0", aer_valid, aer_out, fifo_full); end
    checks++; if (drop_count !== 8'd0 || ts_now !== 20'h0) begin failures++; $display("FAIL arst_cnt got drops=%0d ts=%h exp 0/00000", drop_count, ts_now); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int j = 0; j < 10; j++) begin
      step(16'h0, 1'b1);
      checks++; if (aer_valid !== 1'b0) begin failures++; $display("FAIL arst_idle%0d got valid=%b exp=0", j, aer_valid); end
    end
    step(16'h0020, 1'b1);
    step(16'h0, 1'b1);
    checks++; if (aer_valid !== 1'b1 || aer_out !== 24'h50000A) begin failures++; $display("FAIL arst_new got valid=%b out=%h exp valid=1 out=50000A", aer_valid, aer_out); end
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic [15:0] spk;
      logic        rdy;
      logic        e_valid;
      logic [23:0] e_out;
      if (cyc < 300) begin
        spk = 16'($urandom) & 16'($urandom) & 16'($urandom);
        rdy = ($urandom_range(0, 3) != 0);
      end else begin
        spk = 16'($urandom) & 16'($urandom);
        rdy = ($urandom_range(0, 3) == 0);
      end
      step(spk, rdy);
      e_valid = (m_q.size() != 0);
      e_out = e_valid ? m_q[0] : 24'h0;
      checks++; if (aer_valid !== e_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, aer_valid, e_valid); end
      checks++; if (aer_out !== e_out) begin failures++; $display("FAIL rnd_out cyc=%0d got=%h exp=%h", cyc, aer_out, e_out); end
      checks++; if (fifo_full !== (m_q.size() == DEPTH)) begin failures++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", cyc, fifo_full, m_q.size() == DEPTH); end
      checks++; if (drop_count !== 8'(m_drops)) begin failures++; $display("FAIL rnd_drops cyc=%0d got=%0d exp=%0d", cyc, drop_count, m_drops); end
      checks++; if (ts_now !== 20'(m_ts)) begin failures++; $display("FAIL rnd_ts cyc=%0d got=%h exp=%h", cyc, ts_now, 20'(m_ts)); end
    end
    checks++; if (drop_count !== 8'd255) begin failures++; $display("FAIL rnd_saturate got=%0d exp=255", drop_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_back_pressure();
    test_drop();
    test_wrap();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
